// File: rtl/extensor_parametrizado.sv
// Registered immediate extender between decode and the ALU/PC-adder muxes.
// Turns an IN_W-bit immediate into an OUT_W-bit operand in one of four modes:
// zero-extend, sign-extend, sign-extend-and-shift, or prefix-load (which
// accumulates up to MAX_PFX fields that become the upper bits of the next
// immediate). Valid/ready handshake on both sides, one result per cycle.
// Parameters must satisfy OUT_W >= IN_W*(MAX_PFX+1) and MAX_PFX >= 1.
//
// Ports:
//   Clock       rising-edge clock
//   Reset_n     synchronous active-low reset
//   Entrada     immediate field
//   Modo        00 zero-ext, 01 sign-ext, 10 sign-ext << SHIFT, 11 prefix-load
//   Valido_in   Entrada/Modo valid
//   Pronto_out  block can accept input this cycle (combinational)
//   Saida       extended result (registered)
//   Valido_out  Saida valid
//   Pronto_in   downstream accepts Saida this cycle
//   Prefixado   one or more prefix fields pending
//   Erro        sticky prefix-overflow flag, cleared only by reset
module extensor_parametrizado #(
  parameter int unsigned IN_W    = 5,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned SHIFT   = 1,
  parameter int unsigned MAX_PFX = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [IN_W-1:0]  Entrada,
  input  logic [1:0]       Modo,
  input  logic             Valido_in,
  output logic             Pronto_out,
  output logic [OUT_W-1:0] Saida,
  output logic             Valido_out,
  input  logic             Pronto_in,
  output logic             Prefixado,
  output logic             Erro
);

  localparam int unsigned PW = IN_W * MAX_PFX;        // prefix register width
  localparam int unsigned FW = IN_W * (MAX_PFX + 1);  // widest assembled immediate
  localparam int unsigned CW = $clog2(MAX_PFX + 1);   // prefix count width

  localparam logic [1:0] MODO_ZEXT  = 2'b00;
  localparam logic [1:0] MODO_SEXT  = 2'b01;
  localparam logic [1:0] MODO_SHIFT = 2'b10;
  localparam logic [1:0] MODO_PFX   = 2'b11;

  typedef enum logic {LIVRE, PREFIXO} estado_t;

  estado_t          estado;
  logic [PW-1:0]    prefixo;
  logic [CW-1:0]    contagem;
  logic             aceita;
  logic [FW-1:0]    valor;
  logic             sinal;
  logic [OUT_W-1:0] alto;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] resultado;

  assign Pronto_out = !Valido_out || Pronto_in;
  assign aceita     = Valido_in && Pronto_out;
  assign Prefixado  = (estado == PREFIXO);

  // Prefix bits above the current count are always zero, so the full
  // concatenation is already V zero-extended to FW bits.
  assign valor = {prefixo, Entrada};

  // Extension of V: sign bit and the fill mask depend on the prefix count.
  always_comb begin
    int w;
    sinal = 1'b0;
    alto  = '0;
    w     = int'(IN_W) * (int'(contagem) + 1);
    for (int k = 0; k <= int'(MAX_PFX); k++) begin
      if (contagem == CW'(k)) sinal = valor[int'(IN_W) * (k + 1) - 1];
    end
    for (int i = 0; i < int'(OUT_W); i++) begin
      alto[i] = (i >= w);
    end
    zext = OUT_W'(valor);
    sext = zext | (sinal ? alto : '0);
    case (Modo)
      MODO_SEXT:  resultado = sext;
      MODO_SHIFT: resultado = sext << SHIFT;
      default:    resultado = zext;
    endcase
  end

  // Prefix state machine and output register.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      estado     <= LIVRE;
      prefixo    <= '0;
      contagem   <= '0;
      Saida      <= '0;
      Valido_out <= 1'b0;
      Erro       <= 1'b0;
    end else if (aceita && (Modo == MODO_PFX)) begin
      // Accept implies the output register is empty or draining this cycle.
      Valido_out <= 1'b0;
      if (contagem < CW'(MAX_PFX)) begin
        prefixo  <= PW'({prefixo, Entrada});
        contagem <= contagem + CW'(1);
        estado   <= PREFIXO;
      end else begin
        Erro <= 1'b1;
      end
    end else if (aceita) begin
      Saida      <= resultado;
      Valido_out <= 1'b1;
      prefixo    <= '0;
      contagem   <= '0;
      estado     <= LIVRE;
    end else if (Valido_out && Pronto_in) begin
      Valido_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_extensor_parametrizado.sv
// Directed bench for extensor_parametrizado with hand-computed expectations.
module tb_extensor_parametrizado;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [4:0]  Entrada;
  logic [1:0]  Modo;
  logic        Valido_in;
  logic        Pronto_out;
  logic [15:0] Saida;
  logic        Valido_out;
  logic        Pronto_in;
  logic        Prefixado;
  logic        Erro;

  int total = 0;
  int bad   = 0;

  extensor_parametrizado #(
    .IN_W(5), .OUT_W(16), .SHIFT(1), .MAX_PFX(2)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Entrada    (Entrada),
    .Modo       (Modo),
    .Valido_in  (Valido_in),
    .Pronto_out (Pronto_out),
    .Saida      (Saida),
    .Valido_out (Valido_out),
    .Pronto_in  (Pronto_in),
    .Prefixado  (Prefixado),
    .Erro       (Erro)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [4:0] e);
    Valido_in = v;
    Modo      = m;
    Entrada   = e;
  endtask

  initial begin
    Reset_n   = 1'b0;
    Pronto_in = 1'b1;
    drive(1'b1, 2'b11, 5'b00001);

    // Reset with prefix-load held on the inputs
    step(); step();
    chk("rst_saida", 32'(Saida), 32'h0000);
    chk("rst_vout", 32'(Valido_out), 0);
    chk("rst_pfx", 32'(Prefixado), 0);
    chk("rst_erro", 32'(Erro), 0);
    chk("rst_pout", 32'(Pronto_out), 1);
    Reset_n = 1'b1;
    drive(1'b0, 2'b00, 5'b00000);
    step();
    chk("rel_vout", 32'(Valido_out), 0);
    chk("rel_pfx", 32'(Prefixado), 0);

    // Basic modes back-to-back
    drive(1'b1, 2'b01, 5'b10110);
    step();
    chk("sext", 32'(Saida), 32'hFFF6);
    chk("sext_v", 32'(Valido_out), 1);
    drive(1'b1, 2'b00, 5'b10110);
    step();
    chk("zext", 32'(Saida), 32'h0016);
    chk("zext_v", 32'(Valido_out), 1);
    drive(1'b1, 2'b10, 5'b11111);
    step();
    chk("shift", 32'(Saida), 32'hFFFE);
    chk("shift_v", 32'(Valido_out), 1);
    drive(1'b0, 2'b00, 5'b00000);
    step();
    chk("drain_v", 32'(Valido_out), 0);
    chk("drain_hold", 32'(Saida), 32'hFFFE);

    // Single prefix, positive result
    drive(1'b1, 2'b11, 5'b00001);
    step();
    chk("p1_pfx", 32'(Prefixado), 1);
    chk("p1_vout", 32'(Valido_out), 0);
    drive(1'b1, 2'b01, 5'b10000);
    step();
    chk("p1_res", 32'(Saida), 32'h0030);
    chk("p1_pfx_clr", 32'(Prefixado), 0);
    // Drain + prefix accept in the same cycle
    drive(1'b1, 2'b11, 5'b10000);
    step();
    chk("p2_vout", 32'(Valido_out), 0);
    chk("p2_pfx", 32'(Prefixado), 1);
    drive(1'b1, 2'b01, 5'b00000);
    step();
    chk("p2_res", 32'(Saida), 32'hFE00);
    // Two prefixes then zero-extend
    drive(1'b1, 2'b11, 5'b00001);
    step();
    drive(1'b1, 2'b11, 5'b00010);
    step();
    chk("p3_pfx", 32'(Prefixado), 1);
    drive(1'b1, 2'b00, 5'b00011);
    step();
    chk("p3_res", 32'(Saida), 32'h0443);
    drive(1'b0, 2'b00, 5'b00000);
    step();

    // Backpressure
    drive(1'b1, 2'b01, 5'b10110);
    step();
    chk("bp_first", 32'(Saida), 32'hFFF6);
    Pronto_in = 1'b0;
    drive(1'b1, 2'b00, 5'b00011);
    #1;
    chk("bp_pout", 32'(Pronto_out), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_saida", 32'(Saida), 32'hFFF6);
      chk("bp_vout", 32'(Valido_out), 1);
      chk("bp_pfx", 32'(Prefixado), 0);
      chk("bp_pout_hold", 32'(Pronto_out), 0);
    end
    Pronto_in = 1'b1;
    step();
    chk("bp_new", 32'(Saida), 32'h0003);
    chk("bp_new_v", 32'(Valido_out), 1);
    drive(1'b0, 2'b00, 5'b00000);
    step();
    chk("bp_drain", 32'(Valido_out), 0);

    // Prefix overflow
    drive(1'b1, 2'b11, 5'b00001);
    step();
    drive(1'b1, 2'b11, 5'b00010);
    step();
    chk("ov_erro0", 32'(Erro), 0);
    drive(1'b1, 2'b11, 5'b00011);
    step();
    chk("ov_erro1", 32'(Erro), 1);
    chk("ov_pfx", 32'(Prefixado), 1);
    drive(1'b1, 2'b00, 5'b00100);
    step();
    chk("ov_res", 32'(Saida), 32'h0444);
    chk("ov_pfx_clr", 32'(Prefixado), 0);
    drive(1'b0, 2'b00, 5'b00000);
    step();
    chk("ov_sticky", 32'(Erro), 1);

    // Reset with an output stalled
    Pronto_in = 1'b0;
    drive(1'b1, 2'b00, 5'b00101);
    step();
    chk("st_res", 32'(Saida), 32'h0005);
    drive(1'b1, 2'b11, 5'b00001);
    step();
    chk("st_vout", 32'(Valido_out), 1);
    Reset_n = 1'b0;
    step();
    chk("mr_saida", 32'(Saida), 32'h0000);
    chk("mr_vout", 32'(Valido_out), 0);
    chk("mr_erro", 32'(Erro), 0);
    chk("mr_pfx", 32'(Prefixado), 0);
    // Reset with a prefix pending
    Reset_n   = 1'b1;
    Pronto_in = 1'b1;
    drive(1'b1, 2'b11, 5'b00001);
    step();
    chk("mp_pfx", 32'(Prefixado), 1);
    Reset_n = 1'b0;
    drive(1'b0, 2'b00, 5'b00000);
    step();
    chk("mp_pfx_clr", 32'(Prefixado), 0);
    Reset_n = 1'b1;
    drive(1'b1, 2'b01, 5'b10110);
    step();
    chk("mp_res", 32'(Saida), 32'hFFF6);
    chk("mp_vout", 32'(Valido_out), 1);
    drive(1'b0, 2'b00, 5'b00000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/extensor_parametrizado.md
Name: extensor_parametrizado

Overview:
Parametrised, registered successor to the fixed 5->8 and 2->8 extenders in the datapath. It turns an IN_W-bit immediate into an OUT_W-bit operand and supports four modes: zero-extend, sign-extend, sign-extend-and-shift for branch offsets, and prefix-load. Prefix-load lets consecutive instructions build wide immediates. It sits between decode and the ALU/PC-adder input muxes, with a valid/ready handshake on both sides.

Parameters:
IN_W, 5, width of the immediate field on Entrada.
OUT_W, 16, width of Saida. Legal only if OUT_W >= IN_W*(MAX_PFX+1).
SHIFT, 1, left-shift amount applied in mode 2'b10.
MAX_PFX, 2, maximum number of prefix fields accumulated before a terminating immediate.

Ports:
Clock  input  1  system clock; all state updates on its rising edge.
Reset_n  input  1  synchronous, active-low reset.
Entrada  input  IN_W  immediate field.
Modo  input  2  00 zero-ext, 01 sign-ext, 10 sign-ext then shift left by SHIFT, 11 prefix-load.
Valido_in  input  1  Entrada/Modo valid.
Pronto_out  output  1  block can accept input this cycle.
Saida  output  OUT_W  extended result (registered).
Valido_out  output  1  Saida valid.
Pronto_in  input  1  downstream accepts Saida this cycle.
Prefixado  output  1  one or more prefix fields are pending.
Erro  output  1  sticky: a prefix was dropped because MAX_PFX was exceeded.

Behaviour:
- Reset (Reset_n=0 at a rising edge): Saida=0, Valido_out=0, Prefixado=0, Erro=0, prefix register=0, prefix count=0.
- Pronto_out = !Valido_out || Pronto_in (combinational). Accept = Valido_in && Pronto_out.
- Output drain: if Valido_out && Pronto_in and no result is accepted in the same cycle, Valido_out goes to 0 next cycle. Saida holds its value.
- Stall: while Valido_out=1 and Pronto_in=0, Saida and Valido_out are frozen and no input is accepted, including prefix-load.
- State machine:
  - States LIVRE (count=0) and PREFIXO (1 <= count <= MAX_PFX). Prefixado = (state == PREFIXO).
  - Accept with Modo=11 and count<MAX_PFX: prefix register = {prefix[..], Entrada} (shift left by IN_W, insert Entrada at the LSBs); count+1; go to PREFIXO. No output is produced.
  - Accept with Modo=11 and count==MAX_PFX: Entrada is ignored, prefix register and count are unchanged, Erro is set to 1.
  - Accept with Modo 00/01/10: form V = {prefix (count*IN_W bits), Entrada}, of width W = IN_W*(count+1). Then clear prefix and count and go to LIVRE.
- Extension of V:
  - Mode 00: zero-extend V to OUT_W.
  - Mode 01: replicate V[W-1] into bits OUT_W-1..W.
  - Mode 10: sign-extend as in mode 01, shift left by SHIFT, keep the low OUT_W bits. Bits shifted out are discarded silently.
- Latency: result appears on Saida with Valido_out=1 on the cycle after accept (1 cycle).
- Simultaneous drain + accept: Valido_out stays 1 and Saida takes the new value. There is no bubble, so the block sustains one result per cycle.
- Simultaneous drain + prefix accept: Valido_out goes to 0 and the prefix updates.
- Erro is cleared only by reset.
- Reset mid-sequence (prefix pending or output stalled) discards everything and returns to the reset values above.
- Modo and Entrada are ignored when Valido_in=0 or Pronto_out=0.

Test Plan:
1. Reset: hold Reset_n=0 for 2 cycles with Valido_in=1, Modo=11 -> Saida=16'h0000, Valido_out=0, Prefixado=0, Erro=0, Pronto_out=1. Release reset -> no spurious output.
2. Basic modes, Pronto_in=1:
   - Entrada=5'b10110, Modo=01 -> next cycle Saida=16'hFFF6, Valido_out=1.
   - Same Entrada, Modo=00 -> Saida=16'h0016.
   - Entrada=5'b11111, Modo=10 -> Saida=16'hFFFE.
   - Back-to-back every cycle -> Valido_out held at 1, one result per cycle.
3. Prefix:
   - Modo=11 with Entrada=00001, then Modo=01 with Entrada=10000 -> Prefixado=1 between the two accepts, then Saida=16'h0030.
   - Modo=11 with Entrada=10000, then Modo=01 with Entrada=00000 -> Saida=16'hFE00.
   - Two prefixes 00001, 00010, then Modo=00 with Entrada=00011 -> Saida=16'h0443.
4. Backpressure: produce 16'hFFF6, then Pronto_in=0 for 3 cycles while Valido_in=1 with new data -> Saida and Valido_out unchanged, Pronto_out=0, prefix count unchanged. Raise Pronto_in -> pending input accepted, its result appears next cycle.
5. Prefix overflow: three Modo=11 accepts (00001, 00010, 00011) -> Erro=1 after the third. Then Modo=00 with Entrada=00100 -> Saida=16'h0444 (the third prefix is dropped). Erro stays 1 until reset.
6. Reset mid-operation: one prefix accepted and an output stalled with Pronto_in=0, then Reset_n=0 for one cycle -> all outputs at reset values. Next Modo=01 with Entrada=10110 -> Saida=16'hFFF6 (no stale prefix).
